prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Streams a program into instruction memory and holds the CPU until the load completes.
// Optional zero fill of the unused tail is enabled by defining LOADER_ZERO_FILL_EN.
module prog_loader #(
   parameter int INSTR_SIZE   = 12,
   parameter int ADDR_SIZE    = 5,
   parameter int PROGRAM_SIZE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INSTR_SIZE-1:0] in_data,
   input  logic                  in_last,
   output logic                  mem_we,
   output logic [ADDR_SIZE-1:0]  mem_addr,
   output logic [INSTR_SIZE-1:0] mem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  overflow
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
`ifdef LOADER_ZERO_FILL_EN
      FILL,
`endif
      DONE
   } state_t;

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(PROGRAM_SIZE - 1);

   state_t               state, next;
   logic [ADDR_SIZE-1:0] cnt;
   logic                 accept;
   logic                 fill_we;
   logic                 inc_cnt;
   logic                 clr_cnt;
   logic                 set_ov;
   logic                 enter_done;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      next     = state;
      in_ready = 1'b0;
      cpu_hold = 1'b1;
      accept   = 1'b0;
      fill_we  = 1'b0;
      inc_cnt  = 1'b0;
      clr_cnt  = 1'b0;
      set_ov   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next    = LOAD;
               clr_cnt = 1'b1;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) begin
               inc_cnt = 1'b1;
               // Hitting the last address ends the load whether or not in_last was seen.
               if (cnt == LAST_ADDR) begin
                  next   = DONE;
                  set_ov = ~in_last;
               end else if (in_last) begin
`ifdef LOADER_ZERO_FILL_EN
                  next = FILL;
`else
                  next = DONE;
`endif
               end
            end
         end
`ifdef LOADER_ZERO_FILL_EN
         FILL: begin
            fill_we = 1'b1;
            inc_cnt = 1'b1;
            if (cnt == LAST_ADDR) next = DONE;
         end
`endif
         DONE: begin
            cpu_hold = 1'b0;
            if (start) begin
               next    = LOAD;
               clr_cnt = 1'b1;
            end
         end
         default: next = IDLE;
      endcase
   end

   assign enter_done = (next == DONE) && (state != DONE);

   // Writes are registered, so load_done lines up with the final memory write.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         load_done <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         mem_we    <= accept | fill_we;
         load_done <= enter_done;
         if (accept | fill_we) begin
            mem_addr  <= cnt;
            mem_wdata <= accept ? in_data : '0;
         end
         if (clr_cnt)      cnt <= '0;
         else if (inc_cnt) cnt <= cnt + 1'b1;
         if (clr_cnt)     overflow <= 1'b0;
         else if (set_ov) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a transaction-level model predicts the write list,
// overflow and load_done for each load and the monitored memory writes are compared to it.
module tb_prog_loader;

   localparam int IS = 12;
   localparam int AS = 5;
   localparam int PS = 16;
`ifdef LOADER_ZERO_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IS-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          mem_we;
   logic [AS-1:0] mem_addr;
   logic [IS-1:0] mem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          overflow;

   prog_loader #(.INSTR_SIZE(IS), .ADDR_SIZE(AS), .PROGRAM_SIZE(PS)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write/pulse monitor
   int   cyc = 0;
   int   got_addr[$];
   int   got_data[$];
   int   done_pulses = 0;
   int   done_cyc = -1;
   int   last_wr_cyc = -2;
   logic prev_hold = 1'b1;

   always @(negedge clk) begin
      cyc++;
      if (mem_we === 1'b1) begin
         got_addr.push_back(int'(mem_addr));
         got_data.push_back(int'(mem_wdata));
         last_wr_cyc = cyc;
      end
      if (load_done === 1'b1) begin
         done_pulses++;
         done_cyc = cyc;
         check("done_with_hold_fall", {30'd0, prev_hold, cpu_hold}, 32'd2);
      end
      prev_hold = cpu_hold;
   end

   // Load description and reference model
   logic [IS-1:0] w[32];
   int n;
   int last_idx;
   int exp_addr[$];
   int exp_data[$];
   int exp_k;
   bit exp_ov;

   task automatic model();
      bit ended = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      exp_k = 0;
      for (int i = 0; i < n; i++) begin
         if (exp_k == PS) break;
         exp_k++;
         if (i == last_idx) begin
            ended = 1'b1;
            break;
         end
      end
      for (int i = 0; i < exp_k; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back(int'(w[i]));
      end
      if (FILL_EN && ended)
         for (int a = exp_k; a < PS; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(0);
         end
      exp_ov = !ended && (exp_k == PS);
   endtask

   task automatic compare_writes();
      check("wr_count", got_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         check($sformatf("wr_addr[%0d]", i), got_addr[i], exp_addr[i]);
         check($sformatf("wr_data[%0d]", i), got_data[i], exp_data[i]);
      end
   endtask

   // gaps: idle cycles before each word after the first (-1 = random); rst_after: word index at which rst hits
   task automatic run_load(input int gaps, input int rst_after);
      int idle;
      model();
      got_addr.delete();
      got_data.delete();
      done_pulses = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("start_hold", cpu_hold, 1);
      check("start_ready", in_ready, 1);
      check("start_ov_clear", overflow, 0);
      for (int i = 0; i < n; i++) begin
         if (i == rst_after) begin
            in_valid = 1'b1;
            in_data  = w[i];
            rst      = 1'b1;
            @(negedge clk);
            rst      = 1'b0;
            in_valid = 1'b0;
            check("rst_mem_we", mem_we, 0);
            check("rst_hold", cpu_hold, 1);
            check("rst_ready", in_ready, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_wdata", mem_wdata, 0);
            @(negedge clk);
            check("rst_mem_we2", mem_we, 0);
            exp_addr.delete();
            exp_data.delete();
            for (int j = 0; j < rst_after; j++) begin
               exp_addr.push_back(j);
               exp_data.push_back(int'(w[j]));
            end
            compare_writes();
            check("rst_done_pulses", done_pulses, 0);
            return;
         end
         if (i >= exp_k) begin
            // Word beyond the end of the load must not be taken.
            in_valid = 1'b1;
            in_data  = w[i];
            repeat (2) begin
               @(negedge clk);
               check("ready_after_end", in_ready, 0);
            end
            in_valid = 1'b0;
            break;
         end
         idle = (i == 0) ? 0 : ((gaps < 0) ? int'($urandom_range(0, 2)) : gaps);
         for (int j = 0; j < idle; j++) begin
            in_valid = 1'b0;
            in_data  = IS'($urandom);
            start    = $urandom_range(0, 1) == 1;
            @(negedge clk);
            start    = 1'b0;
         end
         in_valid = 1'b1;
         in_data  = w[i];
         in_last  = (i == last_idx);
         check($sformatf("ready_word%0d", i), in_ready, 1);
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      for (int t = 0; t < 60 && cpu_hold !== 1'b0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      compare_writes();
      check("done_pulses", done_pulses, 1);
      check("done_at_last_write", done_cyc, last_wr_cyc);
      check("overflow", overflow, exp_ov);
      check("hold_released", cpu_hold, 0);
   endtask

   logic [IS-1:0] prog32[11] = '{12'h505, 12'hC11, 12'hE0E, 12'h111, 12'hC10, 12'hBFF,
                                 12'hC11, 12'h700, 12'hB01, 12'hEFA, 12'hDF9};

   initial begin
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ready", in_ready, 0);
      check("reset_hold", cpu_hold, 1);
      check("reset_mem_we", mem_we, 0);
      check("reset_addr", mem_addr, 0);
      check("reset_wdata", mem_wdata, 0);
      check("reset_done", load_done, 0);
      check("reset_ov", overflow, 0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("idle_hold", cpu_hold, 1);

      // Reference program, continuous valid
      n = 11; last_idx = 10;
      for (int i = 0; i < n; i++) w[i] = prog32[i];
      run_load(0, -1);

      // Two words with two idle cycles between them
      n = 2; last_idx = 1;
      for (int i = 0; i < n; i++) w[i] = IS'($urandom);
      run_load(2, -1);

      // Seventeen words, no in_last
      n = 17; last_idx = -1;
      for (int i = 0; i < n; i++) w[i] = IS'($urandom);
      run_load(-1, -1);

      // Restart from DONE with overflow set
      n = 3; last_idx = 2;
      for (int i = 0; i < n; i++) w[i] = IS'($urandom);
      run_load(0, -1);

      // Reset after third accepted word, then fresh load
      n = 6; last_idx = 5;
      for (int i = 0; i < n; i++) w[i] = IS'($urandom);
      run_load(0, 3);
      n = 4; last_idx = 3;
      for (int i = 0; i < n; i++) w[i] = IS'($urandom);
      run_load(0, -1);

      // in_last on the final address: no overflow
      n = 16; last_idx = 15;
      for (int i = 0; i < n; i++) w[i] = IS'($urandom);
      run_load(-1, -1);

      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(1, 20));
         if (n >= PS && $urandom_range(0, 1) == 1) last_idx = -1;
         else last_idx = int'($urandom_range(0, (n < PS ? n : PS) - 1));
         for (int i = 0; i < n; i++) w[i] = IS'($urandom);
         run_load(-1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
